ram_n_scrub: RTL and testbench

//   Parametrised Hack-style RAM: WIDTH-bit words, 2**ADDR_W deep.

---
 rtl/ram_n_scrub.sv | 84 ++++++++
 tb/tb_ram_n_scrub.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_n_scrub.sv
// Parametrised word-addressed RAM with combinational read, clocked write and a
// zero-fill scrub engine that runs after reset and whenever clr_i is seen while idle.
module ram_n_scrub #(
  parameter int WIDTH          = 16,
  parameter int ADDR_W         = 3,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WIDTH-1:0]  in_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              clr_i,
  output logic [WIDTH-1:0]  out_o,
  output logic              ready_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clr_i) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        // cnt wraps naturally to 0 on the last word
        cnt_next = cnt + 1'b1;
        if (cnt == '1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The scrub owns the write port; a reset edge never writes
  always_comb begin
    ready_o = (state == IDLE);
    wr_en   = 1'b0;
    wr_addr = address_i;
    wr_data = in_i;
    if (rst_ni) begin
      case (state)
        IDLE:  wr_en = load_i && !clr_i;
        CLEAR: begin
          wr_en   = 1'b1;
          wr_addr = cnt;
          wr_data = '0;
        end
        default: wr_en = 1'b0;
      endcase
    end
    out_o = ready_o ? mem[address_i] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_ram_n_scrub.sv
// Directed bench for ram_n_scrub: an 8x16 scrub-on-reset instance and a 64x32
// instance without reset scrub, checked through an expected-value queue.
module tb_ram_n_scrub;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, load, clr, rdy;
  logic [15:0] din, dout;
  logic [2:0]  addr;

  logic        rst_nb, load_b, clr_b, rdy_b;
  logic [31:0] din_b, dout_b;
  logic [5:0]  addr_b;

  ram_n_scrub #(.WIDTH(16), .ADDR_W(3), .CLEAR_ON_RESET(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .in_i(din), .load_i(load), .address_i(addr),
    .clr_i(clr), .out_o(dout), .ready_o(rdy)
  );

  ram_n_scrub #(.WIDTH(32), .ADDR_W(6), .CLEAR_ON_RESET(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_nb), .in_i(din_b), .load_i(load_b), .address_i(addr_b),
    .clr_i(clr_b), .out_o(dout_b), .ready_o(rdy_b)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];
  logic [15:0] ref_a [8];
  logic [15:0] sweep_exp [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic rd_a(input logic [2:0] a, input string tag);
    addr = a;
    expect_v({16'h0, ref_a[a]});
    #1;
    check(tag, {16'h0, dout});
  endtask

  task automatic wr_a(input logic [2:0] a, input logic [15:0] v, input string tag);
    addr = a;
    din  = v;
    load = 1'b1;
    ref_a[a] = v;
    expect_v({16'h0, v});
    tick();
    check(tag, {16'h0, dout});
    load = 1'b0;
  endtask

  // n scrub edges: ready stays low with out forced to 0 until the n-th edge
  task automatic scrub_a(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      tick();
      expect_v({31'h0, (k == n)});
      check({tag, "_rdy"}, {31'h0, rdy});
      if (k < n) begin
        expect_v(32'h0);
        check({tag, "_out"}, {16'h0, dout});
      end
    end
    for (int i = 0; i < 8; i++) ref_a[i] = 16'h0;
  endtask

  task automatic read_all_a(input string tag);
    for (int i = 0; i < 8; i++) rd_a(i[2:0], tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; clr = 1'b0; din = '0; addr = '0;
    rst_nb = 1'b0; load_b = 1'b0; clr_b = 1'b0; din_b = '0; addr_b = '0;
    sweep_exp = '{16'h0, 16'h8285, 16'hFEB9, 16'h2B67, 16'h0, 16'h0, 16'h0, 16'h3039};

    // 1: reset then power-on scrub
    tick();
    tick();
    expect_v(32'h0); check("rst_rdy", {31'h0, rdy});
    expect_v(32'h0); check("rst_out", {16'h0, dout});
    expect_v(32'h1); check("b_rst_rdy", {31'h0, rdy_b});
    rst_n  = 1'b1;
    rst_nb = 1'b1;
    scrub_a(8, "por");
    read_all_a("por_read");

    // 2: writes of negative and positive words, then sweep with load low
    wr_a(3'd1, -16'sd32123, "wr1");
    wr_a(3'd2, -16'sd327,   "wr2");
    wr_a(3'd3, 16'd11111,   "wr3");
    wr_a(3'd7, 16'd12345,   "wr7");
    din = 16'h1;
    for (int i = 0; i < 8; i++) begin
      addr = i[2:0];
      expect_v({16'h0, sweep_exp[i]});
      #1;
      check("sweep", {16'h0, dout});
    end
    tick();
    read_all_a("hold");

    // 3: clr with a simultaneous load: clear wins, no write
    for (int i = 0; i < 8; i++) wr_a(i[2:0], 16'h1000 + 16'(i), "fill");
    clr = 1'b1; load = 1'b1; din = 16'd5; addr = 3'd4;
    tick();
    clr = 1'b0; load = 1'b0;
    expect_v(32'h0); check("clr_rdy", {31'h0, rdy});
    expect_v(32'h0); check("clr_out", {16'h0, dout});
    scrub_a(8, "clr");
    read_all_a("clr_read");

    // 4: reset in the middle of a scrub restarts it from word 0
    for (int i = 0; i < 8; i++) wr_a(i[2:0], 16'hAAAA, "fillA");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_v(32'h0); check("mid_rst_rdy", {31'h0, rdy});
    scrub_a(8, "restart");
    read_all_a("restart_read");

    // 5: load during a scrub is ignored
    for (int i = 0; i < 8; i++) wr_a(i[2:0], 16'h1234, "fill5");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    load = 1'b1; din = 16'hBEEF;
    for (int k = 1; k <= 7; k++) begin
      addr = k[2:0];
      tick();
      expect_v(32'h0); check("ld_scrub_out", {16'h0, dout});
      expect_v(32'h0); check("ld_scrub_rdy", {31'h0, rdy});
    end
    load = 1'b0;
    tick();
    expect_v(32'h1); check("ld_scrub_done", {31'h0, rdy});
    for (int i = 0; i < 8; i++) ref_a[i] = 16'h0;
    read_all_a("ld_scrub_read");

    // clr held high: a new scrub starts on the first IDLE edge
    wr_a(3'd6, 16'h5A5A, "pre_hold");
    clr = 1'b1;
    tick();
    scrub_a(8, "hold1");
    tick();
    expect_v(32'h0); check("hold_restart", {31'h0, rdy});
    clr = 1'b0;
    scrub_a(8, "hold2");
    read_all_a("hold_read");

    // 6: 64x32 instance without reset scrub
    addr_b = 6'd63; din_b = 32'hDEADBEEF; load_b = 1'b1;
    tick();
    load_b = 1'b0;
    expect_v(32'hDEADBEEF); check("b_wr63", dout_b);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      expect_v({31'h0, (k == 64)});
      check("b_scrub_rdy", {31'h0, rdy_b});
    end
    expect_v(32'h0); check("b_rd63", dout_b);
    addr_b = 6'd0;
    #1;
    expect_v(32'h0); check("b_rd0", dout_b);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
